// File: rtl/calc_cmd_driver.sv
// Command FIFO and handshake driver for a seven-segment calculator core.
// Issues queued key codes one at a time and decodes the display on '='.
module calc_cmd_driver #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_valid,
  input  logic [3:0]  push_cmd,
  output logic        push_ready,
  output logic [3:0]  cmd,
  input  logic [1:0]  status,
  input  logic [6:0]  displays [7:0],
  output logic        result_valid,
  output logic [31:0] result_bcd,
  output logic        result_err,
  output logic        timeout,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW:0] DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_RESULT, CAPTURE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [CW-1:0] ack_cnt_q, ack_cnt_d;
  logic [3:0]    last_cmd_q, last_cmd_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   result_bcd_q;
  logic          result_err_q;
  logic          full, empty, do_push, do_pop, capture;
  logic [31:0]   dec_bcd;
  logic          dec_fail;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_push = push_valid && !full && !reset;

  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h3F:   seg_decode = 5'h00;
      7'h06:   seg_decode = 5'h01;
      7'h5B:   seg_decode = 5'h02;
      7'h4F:   seg_decode = 5'h03;
      7'h66:   seg_decode = 5'h04;
      7'h6D:   seg_decode = 5'h05;
      7'h7D:   seg_decode = 5'h06;
      7'h07:   seg_decode = 5'h07;
      7'h7F:   seg_decode = 5'h08;
      7'h6F:   seg_decode = 5'h09;
      7'h00:   seg_decode = 5'h0A;
      7'h40:   seg_decode = 5'h0B;
      default: seg_decode = 5'h1F;  // bit 4 flags an unrecognised pattern
    endcase
  endfunction

  always_comb begin
    logic [4:0] d;
    d        = '0;
    dec_bcd  = '0;
    dec_fail = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      d                  = seg_decode(displays[i]);
      dec_bcd[i*4 +: 4]  = d[3:0];
      dec_fail           = dec_fail | d[4];
    end
  end

  always_comb begin
    state_d    = state_q;
    ack_cnt_d  = ack_cnt_q;
    last_cmd_d = last_cmd_q;
    timeout_d  = timeout_q;
    do_pop     = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: if (!empty && status == 2'b10) state_d = ISSUE;
      ISSUE: begin
        do_pop     = 1'b1;
        last_cmd_d = mem_q[rd_ptr_q];
        ack_cnt_d  = '0;
        state_d    = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (status != 2'b10) begin
          state_d = (last_cmd_q == 4'b1110) ? WAIT_RESULT : IDLE;
        end else if (ack_cnt_q == ACK_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      // Results are latched on the edge entering CAPTURE so the valid pulse
      // lines up with the updated fields one cycle after status leaves busy.
      WAIT_RESULT: if (status != 2'b00) begin
        capture = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_cmd;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ack_cnt_q    <= '0;
      last_cmd_q   <= 4'hF;
      timeout_q    <= 1'b0;
      result_bcd_q <= '0;
      result_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_cnt_q  <= ack_cnt_d;
      last_cmd_q <= last_cmd_d;
      timeout_q  <= timeout_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      if (capture) begin
        result_bcd_q <= dec_bcd;
        result_err_q <= (status != 2'b10) | dec_fail;
      end
    end
  end

  // Outputs are forced to their idle values combinationally while reset is high.
  assign push_ready   = reset | ~full;
  assign cmd          = (state_q == ISSUE && !reset) ? mem_q[rd_ptr_q] : 4'hF;
  assign result_valid = (state_q == CAPTURE) && !reset;
  assign result_bcd   = reset ? '0 : result_bcd_q;
  assign result_err   = result_err_q & ~reset;
  assign timeout      = timeout_q & ~reset;
  assign busy         = !reset && (state_q != IDLE || !empty);

endmodule

// File: tb/tb_calc_cmd_driver.sv
// Directed bench for calc_cmd_driver with a small reactive calculator model.
module tb_calc_cmd_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic        push_valid;
  logic [3:0]  push_cmd;
  logic        push_ready;
  logic [3:0]  cmd;
  logic [1:0]  status;
  logic [6:0]  disp [7:0];
  logic        result_valid;
  logic [31:0] result_bcd;
  logic        result_err;
  logic        timeout;
  logic        busy;

  calc_cmd_driver #(.DEPTH(8), .ACK_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .push_valid(push_valid), .push_cmd(push_cmd),
    .push_ready(push_ready), .cmd(cmd), .status(status), .displays(disp),
    .result_valid(result_valid), .result_bcd(result_bcd), .result_err(result_err),
    .timeout(timeout), .busy(busy)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [3:0]  q_cmds [$];
  int          rv_cnt = 0;
  logic [31:0] cap_bcd = '0;
  logic        cap_err = 1'b0;

  bit          model_en = 1'b0;
  bit          eq_hold  = 1'b0;
  logic [1:0]  eq_status = 2'b10;
  logic [6:0]  eq_disp [7:0];
  int          m_stage = 0;
  int          m_idx   = 0;
  logic [3:0]  m_last  = 4'hF;

  always @(negedge clock) begin
    if (cmd !== 4'hF) q_cmds.push_back(cmd);
    if (result_valid === 1'b1) begin
      rv_cnt  = rv_cnt + 1;
      cap_bcd = result_bcd;
      cap_err = result_err;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Calculator: goes busy the cycle after a command, then ready (or result on '=').
  task automatic model_step();
    if (!model_en) return;
    if (m_stage == 0) begin
      if (m_idx < q_cmds.size()) begin
        m_last  = q_cmds[m_idx];
        m_idx++;
        status  = 2'b00;
        m_stage = 1;
      end
    end else if (m_stage == 1) begin
      if (m_last == 4'hE) begin
        if (eq_hold) m_stage = 2;
        else begin
          status  = eq_status;
          disp    = eq_disp;
          m_stage = 0;
        end
      end else begin
        status  = 2'b10;
        m_stage = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    model_step();
    #3;
  endtask

  task automatic push(input logic [3:0] c);
    push_valid = 1'b1;
    push_cmd   = c;
    cycle();
    push_valid = 1'b0;
  endtask

  task automatic do_reset();
    model_en   = 1'b0;
    eq_hold    = 1'b0;
    push_valid = 1'b0;
    status     = 2'b10;
    reset      = 1'b1;
    cycle();
    cycle();
    reset   = 1'b0;
    m_stage = 0;
    m_idx   = q_cmds.size();
  endtask

  task automatic wait_rv(input int target, input int budget, input string tag);
    for (int k = 0; k < budget && rv_cnt < target; k++) cycle();
    check_eq(tag, 32'(rv_cnt), 32'(target));
  endtask

  task automatic wait_issue(input int budget);
    for (int k = 0; k < budget && cmd === 4'hF; k++) cycle();
  endtask

  initial begin
    logic [3:0] exp1 [5];
    int base, rv0, n;
    exp1 = '{4'h1, 4'h2, 4'hC, 4'h3, 4'hE};
    reset = 1'b1; push_valid = 1'b0; push_cmd = '0; status = 2'b10;
    disp = '{default: 7'h00};
    eq_disp = '{default: 7'h00};
    cycle();
    cycle();
    check_eq("rst_cmd",   32'(cmd), 32'hF);
    check_eq("rst_ready", 32'(push_ready), 32'd1);
    check_eq("rst_rv",    32'(result_valid), 32'd0);
    check_eq("rst_bcd",   result_bcd, 32'h0);
    check_eq("rst_err",   32'(result_err), 32'd0);
    check_eq("rst_to",    32'(timeout), 32'd0);
    check_eq("rst_busy",  32'(busy), 32'd0);

    // Sequence 1 2 * 3 = with "36" on a blank display
    do_reset();
    eq_status  = 2'b10;
    eq_disp    = '{default: 7'h00};
    eq_disp[0] = 7'h7D;
    eq_disp[1] = 7'h4F;
    model_en   = 1'b1;
    base = q_cmds.size();
    rv0  = rv_cnt;
    for (int i = 0; i < 5; i++) push(exp1[i]);
    wait_rv(rv0 + 1, 80, "seq_rv");
    check_eq("seq_ncmd", 32'(q_cmds.size() - base), 32'd5);
    for (int i = 0; i < 5; i++)
      check_eq($sformatf("seq_cmd%0d", i),
               32'((base + i < q_cmds.size()) ? q_cmds[base + i] : 4'hX), 32'(exp1[i]));
    check_eq("seq_bcd", cap_bcd, 32'hAAAAAA36);
    check_eq("seq_err", 32'(cap_err), 32'd0);
    for (int i = 0; i < 5; i++) cycle();
    check_eq("seq_hold", result_bcd, 32'hAAAAAA36);
    check_eq("seq_pulse1", 32'(rv_cnt - rv0), 32'd1);
    check_eq("seq_idle", 32'(busy), 32'd0);

    // Fill while calculator busy; ninth push is dropped
    do_reset();
    status = 2'b00;
    base = q_cmds.size();
    for (int i = 1; i <= 9; i++) begin
      push_valid = 1'b1;
      push_cmd   = 4'(i);
      cycle();
      if (i == 7) check_eq("fill_ready7", 32'(push_ready), 32'd1);
      if (i == 8) check_eq("fill_ready8", 32'(push_ready), 32'd0);
    end
    push_valid = 1'b0;
    check_eq("fill_busy", 32'(busy), 32'd1);
    check_eq("fill_noissue", 32'(q_cmds.size() - base), 32'd0);
    m_idx = q_cmds.size(); m_stage = 0;
    status = 2'b10;
    model_en = 1'b1;
    for (int k = 0; k < 120 && (q_cmds.size() - base < 8 || busy); k++) cycle();
    for (int k = 0; k < 10; k++) cycle();
    check_eq("fill_ncmd", 32'(q_cmds.size() - base), 32'd8);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("fill_cmd%0d", i),
               32'((base + i < q_cmds.size()) ? q_cmds[base + i] : 4'hX), 32'(i + 1));
    check_eq("fill_ready_end", 32'(push_ready), 32'd1);

    // Acknowledge timeout
    do_reset();
    push(4'h5);
    wait_issue(10);
    check_eq("to_issue", 32'(cmd), 32'h5);
    n = 0;
    while (timeout !== 1'b1 && n < 40) begin cycle(); n++; end
    check_eq("to_latency", 32'(n), 32'd17);
    check_eq("to_idle", 32'(busy), 32'd0);
    status = 2'b00;
    base = q_cmds.size();
    push(4'h7);
    cycle(); cycle(); cycle();
    check_eq("to_held", 32'(q_cmds.size() - base), 32'd0);
    status = 2'b10;
    wait_issue(10);
    check_eq("to_next", 32'(cmd), 32'h7);
    check_eq("to_sticky", 32'(timeout), 32'd1);

    // '=' with overflow and a bad segment pattern
    do_reset();
    eq_status  = 2'b11;
    eq_disp    = '{default: 7'h00};
    eq_disp[0] = 7'h79;
    eq_disp[1] = 7'h40;
    model_en   = 1'b1;
    rv0 = rv_cnt;
    push(4'hE);
    wait_rv(rv0 + 1, 40, "ovf_rv");
    check_eq("ovf_err", 32'(cap_err), 32'd1);
    check_eq("ovf_nib0", 32'(cap_bcd[3:0]), 32'hF);
    check_eq("ovf_bcd", cap_bcd, 32'hAAAAAABF);
    model_en = 1'b0;
    status   = 2'b10;

    // Reset while a command is on the bus
    do_reset();
    push(4'h4);
    wait_issue(10);
    check_eq("ri_issue", 32'(cmd), 32'h4);
    reset = 1'b1;
    #1;
    check_eq("ri_cmd_rst", 32'(cmd), 32'hF);
    cycle();
    reset = 1'b0;
    base = q_cmds.size();
    for (int k = 0; k < 5; k++) cycle();
    check_eq("ri_noissue", 32'(q_cmds.size() - base), 32'd0);
    check_eq("ri_busy", 32'(busy), 32'd0);

    // Reset during WAIT_RESULT with three commands queued
    do_reset();
    eq_hold  = 1'b1;
    model_en = 1'b1;
    push(4'hE);
    for (int k = 0; k < 20 && m_stage != 2; k++) cycle();
    check_eq("wr_reached", 32'(m_stage), 32'd2);
    push(4'h1); push(4'h2); push(4'h3);
    check_eq("wr_busy", 32'(busy), 32'd1);
    base = q_cmds.size();
    rv0  = rv_cnt;
    reset = 1'b1;
    #1;
    check_eq("wr_rst_cmd",  32'(cmd), 32'hF);
    check_eq("wr_rst_busy", 32'(busy), 32'd0);
    check_eq("wr_rst_rdy",  32'(push_ready), 32'd1);
    cycle();
    reset    = 1'b0;
    model_en = 1'b0;
    m_stage  = 0;
    status   = 2'b10;
    for (int k = 0; k < 10; k++) cycle();
    check_eq("wr_busy_after", 32'(busy), 32'd0);
    check_eq("wr_cmd_after",  32'(cmd), 32'hF);
    check_eq("wr_noissue",    32'(q_cmds.size() - base), 32'd0);
    check_eq("wr_norv",       32'(rv_cnt - rv0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
